// File: rtl/temp_bram_pkg.sv
// Shared types and sizing helpers for the layer temporary-buffer sequencer.
package temp_bram_pkg;

   localparam int unsigned MAC_CNT_DEF = 128;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_CAPTURE = 3'd1;
   localparam state_t ST_STREAM  = 3'd2;
   localparam state_t ST_DRAIN   = 3'd3;
   localparam state_t ST_CLEAR   = 3'd4;
   localparam state_t ST_DONE    = 3'd5;

   // Index width; never below one bit so a single-entry buffer still elaborates.
   function automatic int unsigned addr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/temp_bram_ctrl_if.sv
// Handshake and strobe bundle between the temp-buffer sequencer and its neighbours.
// rd_len_i exists only when TEMP_BRAM_CTRL_LEN_EN is defined.
interface temp_bram_ctrl_if #(
   parameter int unsigned MAC_CNT = temp_bram_pkg::MAC_CNT_DEF
);
   localparam int unsigned ADDR_WIDTH = temp_bram_pkg::addr_width(MAC_CNT);
   localparam int unsigned CNT_WIDTH  = temp_bram_pkg::cnt_width(MAC_CNT);

   logic                  layer_done_i;
   logic                  flush_i;
   logic                  out_ready_i;
`ifdef TEMP_BRAM_CTRL_LEN_EN
   logic [CNT_WIDTH-1:0]  rd_len_i;
`endif
   logic                  wr_temp_en_o;
   logic                  rd_temp_en_o;
   logic [ADDR_WIDTH-1:0] temp_bram_index_o;
   logic                  clear_o;
   logic                  out_valid_o;
   logic                  out_last_o;
   logic                  busy_o;
   logic                  done_o;
   logic                  overrun_err_o;

   modport master (
      input  layer_done_i, flush_i, out_ready_i,
`ifdef TEMP_BRAM_CTRL_LEN_EN
      input  rd_len_i,
`endif
      output wr_temp_en_o, rd_temp_en_o, temp_bram_index_o, clear_o,
      output out_valid_o, out_last_o, busy_o, done_o, overrun_err_o
   );

   modport slave (
      output layer_done_i, flush_i, out_ready_i,
`ifdef TEMP_BRAM_CTRL_LEN_EN
      output rd_len_i,
`endif
      input  wr_temp_en_o, rd_temp_en_o, temp_bram_index_o, clear_o,
      input  out_valid_o, out_last_o, busy_o, done_o, overrun_err_o
   );

endinterface

// File: rtl/temp_bram_ctrl.sv
// Capture / stream / clear sequencer for the layer temporary buffer.
// Optional TEMP_BRAM_CTRL_LEN_EN: per-layer stream length taken from rd_len_i.
module temp_bram_ctrl
   import temp_bram_pkg::*;
#(
   parameter int unsigned MAC_CNT = MAC_CNT_DEF
) (
   input logic              clk_i,
   input logic              rstn_i,
   temp_bram_ctrl_if.master bus
);

   localparam int unsigned ADDR_WIDTH = addr_width(MAC_CNT);
   localparam int unsigned CNT_WIDTH  = cnt_width(MAC_CNT);

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  len_q, len_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  wr_q, wr_d;
   logic                  rd_q, rd_d;
   logic                  rd_last_q, rd_last_d;
   logic                  clr_q, clr_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic                  done_q, done_d;
   logic                  ovr_q, ovr_d;
   logic                  busy;
   logic [CNT_WIDTH-1:0]  len_sel;

   assign busy = (state_q != ST_IDLE);

   // Stream length for the transaction being started; out-of-range lengths mean a full buffer.
`ifdef TEMP_BRAM_CTRL_LEN_EN
   assign len_sel = ((bus.rd_len_i == '0) || (bus.rd_len_i > CNT_WIDTH'(MAC_CNT)))
                    ? CNT_WIDTH'(MAC_CNT) : bus.rd_len_i;
`else
   assign len_sel = CNT_WIDTH'(MAC_CNT);
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin : state_reg
      if (!rstn_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         len_q     <= CNT_WIDTH'(MAC_CNT);
         idx_q     <= '0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         rd_last_q <= 1'b0;
         clr_q     <= 1'b0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         rd_last_q <= rd_last_d;
         clr_q     <= clr_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         done_q    <= done_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin : next_state
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      idx_d     = idx_q;
      wr_d      = 1'b0;
      rd_d      = 1'b0;
      rd_last_d = 1'b0;
      clr_d     = 1'b0;
      done_d    = 1'b0;
      // Read data follows the strobe by one cycle; a flushed final read loses its last tag.
      valid_d   = rd_q;
      last_d    = rd_last_q & ~bus.flush_i;
      ovr_d     = ovr_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.layer_done_i && !bus.flush_i) begin
               wr_d    = 1'b1;
               len_d   = len_sel;
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (bus.out_ready_i) begin
               rd_d  = 1'b1;
               idx_d = cnt_q[ADDR_WIDTH-1:0];
               if (cnt_q == len_q - CNT_WIDTH'(1)) begin
                  rd_last_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = ST_DRAIN;
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         ST_DRAIN: state_d = ST_CLEAR;
         ST_CLEAR: begin
            clr_d   = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort: cancel pending strobes and fall through the clear/done tail.
      if (bus.flush_i && busy) begin
         state_d   = ST_CLEAR;
         cnt_d     = '0;
         idx_d     = idx_q;
         wr_d      = 1'b0;
         rd_d      = 1'b0;
         rd_last_d = 1'b0;
         clr_d     = 1'b0;
         done_d    = 1'b0;
      end

      if (bus.flush_i) begin
         ovr_d = 1'b0;
      end else if (bus.layer_done_i && busy) begin
         ovr_d = 1'b1;
      end
   end

   assign bus.wr_temp_en_o      = wr_q;
   assign bus.rd_temp_en_o      = rd_q;
   assign bus.temp_bram_index_o = idx_q;
   assign bus.clear_o           = clr_q;
   assign bus.out_valid_o       = valid_q;
   assign bus.out_last_o        = last_q;
   assign bus.done_o            = done_q;
   assign bus.overrun_err_o     = ovr_q;
   assign bus.busy_o            = busy;

endmodule

// File: tb/tb_temp_bram_ctrl.sv
// Directed bench for temp_bram_ctrl with a behavioural temp buffer model.
// Also exercises TEMP_BRAM_CTRL_LEN_EN when that macro is defined.
module tb_temp_bram_ctrl;

   localparam int unsigned MAC = 128;
   localparam int unsigned AW  = 7;

   logic clk;
   logic rstn;

   temp_bram_ctrl_if #(.MAC_CNT(MAC)) bus ();

   temp_bram_ctrl #(.MAC_CNT(MAC)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Buffer model: write > read > clear, data_out zero on non-read cycles.
   logic [15:0] mem [MAC];
   logic [15:0] rdata;

   function automatic logic [15:0] pat(input int unsigned i);
      return 16'(i) ^ 16'hA500;
   endfunction

   always @(posedge clk) begin
      if (bus.wr_temp_en_o) begin
         for (int i = 0; i < MAC; i++) mem[i] <= pat(i);
      end else if (bus.clear_o) begin
         for (int i = 0; i < MAC; i++) mem[i] <= 16'h0;
      end
      rdata <= bus.rd_temp_en_o ? mem[bus.temp_bram_index_o] : 16'h0;
   end

   // Event tallies gathered at the falling edge.
   int wr_n, wr_cyc, rd_n, rd_first, rd_lastc, idx_err, rd_noready;
   int v_n, v_first, v_lastc, data_err, last_n, last_idx, last_cyc;
   int clear_n, clear_cyc, done_n, done_cyc, busy_fall, clash;
   int unsigned exp_idx;
   logic busy_prev, ready_prev;
   logic [AW-1:0] pend [$];

   task automatic clear_tally();
      wr_n = 0; wr_cyc = -1; rd_n = 0; rd_first = -1; rd_lastc = -1;
      idx_err = 0; rd_noready = 0; v_n = 0; v_first = -1; v_lastc = -1;
      data_err = 0; last_n = 0; last_idx = -1; last_cyc = -1;
      clear_n = 0; clear_cyc = -1; done_n = 0; done_cyc = -1;
      busy_fall = -1; clash = 0; exp_idx = 0;
      pend.delete();
   endtask

   always @(negedge clk) begin
      logic [AW-1:0] pi;
      if (int'(bus.wr_temp_en_o) + int'(bus.rd_temp_en_o) + int'(bus.clear_o) > 1) clash++;
      if (bus.wr_temp_en_o) begin wr_n++; wr_cyc = int'(cyc); end
      if (bus.rd_temp_en_o) begin
         if (rd_n == 0) rd_first = int'(cyc);
         rd_lastc = int'(cyc);
         if (32'(bus.temp_bram_index_o) != exp_idx) idx_err++;
         if (!ready_prev) rd_noready++;
         pend.push_back(bus.temp_bram_index_o);
         exp_idx++;
         rd_n++;
      end
      if (bus.out_valid_o) begin
         if (v_n == 0) v_first = int'(cyc);
         v_lastc = int'(cyc);
         v_n++;
         if (pend.size() == 0) data_err++;
         else begin
            pi = pend.pop_front();
            if (rdata != pat(32'(pi))) data_err++;
            if (bus.out_last_o) begin
               last_n++; last_idx = int'(pi); last_cyc = int'(cyc);
            end
         end
      end
      if (bus.clear_o) begin clear_n++; clear_cyc = int'(cyc); end
      if (bus.done_o) begin done_n++; done_cyc = int'(cyc); end
      if (busy_prev && !bus.busy_o) busy_fall = int'(cyc);
      busy_prev  = bus.busy_o;
      ready_prev = bus.out_ready_i;
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int outs();
      return int'({bus.wr_temp_en_o, bus.rd_temp_en_o, bus.clear_o, bus.out_valid_o,
                   bus.out_last_o, bus.done_o, bus.overrun_err_o, bus.busy_o,
                   bus.temp_bram_index_o});
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic start(output int c0);
      bus.layer_done_i = 1'b1;
      c0 = int'(cyc);
      step();
      bus.layer_done_i = 1'b0;
   endtask

   // Iteration i is cycle c0+1+i; optional extra layer_done / flush at a given iteration.
   task automatic run(input int budget, input bit bp, input int pulse_at, input int flush_at);
      for (int i = 0; i < budget; i++) begin
         bus.out_ready_i  = bp ? ((i % 4) == 0 || (i % 4) == 3) : 1'b1;
         bus.layer_done_i = (i == pulse_at);
         bus.flush_i      = (i == flush_at);
         step();
         if (done_n > 0) break;
      end
      bus.layer_done_i = 1'b0;
      bus.flush_i      = 1'b0;
      bus.out_ready_i  = 1'b1;
   endtask

   initial begin
      int c0;
      rstn = 1'b0;
      bus.layer_done_i = 1'b0;
      bus.flush_i      = 1'b0;
      bus.out_ready_i  = 1'b1;
`ifdef TEMP_BRAM_CTRL_LEN_EN
      bus.rd_len_i     = '0;
`endif
      busy_prev = 1'b0;
      ready_prev = 1'b0;
      clear_tally();
      step(); step();
      chk("reset_outs", outs(), 0);
      rstn = 1'b1;
      step();
      chk("idle_outs", outs(), 0);

      // Full stream, ready held high
      clear_tally();
      start(c0);
      run(400, 1'b0, -1, -1);
      chk("t1_done_seen", done_n, 1);
      chk("t1_wr_n", wr_n, 1);
      chk("t1_wr_cyc", wr_cyc, c0 + 1);
      chk("t1_rd_first", rd_first, c0 + 3);
      chk("t1_rd_last", rd_lastc, c0 + 130);
      chk("t1_rd_n", rd_n, 128);
      chk("t1_idx_err", idx_err, 0);
      chk("t1_v_first", v_first, c0 + 4);
      chk("t1_v_n", v_n, 128);
      chk("t1_last_n", last_n, 1);
      chk("t1_last_idx", last_idx, 127);
      chk("t1_last_cyc", last_cyc, c0 + 131);
      chk("t1_data_err", data_err, 0);
      chk("t1_clear_cyc", clear_cyc, c0 + 132);
      chk("t1_done_cyc", done_cyc, c0 + 133);
      chk("t1_busy_fall", busy_fall, c0 + 133);
      chk("t1_clash", clash, 0);

      // Backpressure 1,0,0,1
      step();
      clear_tally();
      start(c0);
      run(800, 1'b1, -1, -1);
      chk("t2_done_seen", done_n, 1);
      chk("t2_rd_noready", rd_noready, 0);
      chk("t2_rd_n", rd_n, 128);
      chk("t2_idx_err", idx_err, 0);
      chk("t2_v_n", v_n, 128);
      chk("t2_last_n", last_n, 1);
      chk("t2_last_idx", last_idx, 127);
      chk("t2_data_err", data_err, 0);
      chk("t2_clash", clash, 0);

      // Overrun mid-stream
      step();
      clear_tally();
      start(c0);
      run(400, 1'b0, 20, -1);
      chk("t3_done_seen", done_n, 1);
      chk("t3_wr_n", wr_n, 1);
      chk("t3_rd_n", rd_n, 128);
      chk("t3_idx_err", idx_err, 0);
      chk("t3_last_cyc", last_cyc, c0 + 131);
      chk("t3_data_err", data_err, 0);
      step(); step(); step();
      chk("t3_ovr_idle", int'(bus.overrun_err_o), 1);
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      chk("t3_ovr_clr", int'(bus.overrun_err_o), 0);
      chk("t3_busy_after_flush", int'(bus.busy_o), 0);
      step();
      chk("t3_clear_n", clear_n, 1);

      // Flush after five reads
      clear_tally();
      start(c0);
      run(100, 1'b0, -1, 6);
      chk("t4_done_seen", done_n, 1);
      chk("t4_rd_n", rd_n, 5);
      chk("t4_v_n", v_n, 5);
      chk("t4_v_last", v_lastc, c0 + 8);
      chk("t4_last_n", last_n, 0);
      chk("t4_data_err", data_err, 0);
      chk("t4_clear_cyc", clear_cyc, c0 + 9);
      chk("t4_done_cyc", done_cyc, c0 + 10);
      chk("t4_busy_fall", busy_fall, c0 + 10);

      // flush and layer_done together in IDLE
      step();
      clear_tally();
      bus.layer_done_i = 1'b1;
      bus.flush_i      = 1'b1;
      step();
      bus.layer_done_i = 1'b0;
      bus.flush_i      = 1'b0;
      step(); step(); step();
      chk("t5_wr_n", wr_n, 0);
      chk("t5_busy", int'(bus.busy_o), 0);
      chk("t5_ovr", int'(bus.overrun_err_o), 0);

      // Asynchronous reset mid-stream, then a fresh transaction
      clear_tally();
      start(c0);
      run(20, 1'b0, -1, -1);
      chk("t6_streaming", int'(bus.busy_o), 1);
      rstn = 1'b0;
      #1;
      chk("t6_async_outs", outs(), 0);
      step(); step();
      rstn = 1'b1;
      step();
      clear_tally();
      start(c0);
      run(400, 1'b0, -1, -1);
      chk("t6_done_seen", done_n, 1);
      chk("t6_rd_first", rd_first, c0 + 3);
      chk("t6_rd_n", rd_n, 128);
      chk("t6_idx_err", idx_err, 0);
      chk("t6_data_err", data_err, 0);

`ifdef TEMP_BRAM_CTRL_LEN_EN
      // Short final layer and the zero-length fallback
      step();
      clear_tally();
      bus.rd_len_i = 8'd10;
      start(c0);
      bus.rd_len_i = 8'd0;
      run(400, 1'b0, -1, -1);
      chk("t7_done_seen", done_n, 1);
      chk("t7_rd_n", rd_n, 10);
      chk("t7_last_idx", last_idx, 9);
      chk("t7_last_cyc", last_cyc, c0 + 13);
      chk("t7_done_cyc", done_cyc, c0 + 15);
      step();
      clear_tally();
      bus.rd_len_i = 8'd0;
      start(c0);
      run(400, 1'b0, -1, -1);
      chk("t8_rd_n", rd_n, 128);
      chk("t8_last_idx", last_idx, 127);
      step();
      clear_tally();
      bus.rd_len_i = 8'd200;
      start(c0);
      bus.rd_len_i = 8'd0;
      run(400, 1'b0, -1, -1);
      chk("t9_rd_n", rd_n, 128);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
